// File: rtl/ssp_slave_frame_deser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_pkg
//  Description : Shared types and helpers for the SSP slave frame deserialiser.
//  Revision    : 1.0 - initial release
// ============================================================================
package ssp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        WAIT = 2'd3
    } ssp_state_e;

    // Total frame length: channel + register address + WnR + data.
    function automatic int frame_w(input int ch, input int ra, input int dw);
        return ch + ra + 1 + dw;
    endfunction

    // Channel field width; a single channel needs no field at all.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssp_slave_frame_deser_if.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_slave_frame_deser_if
//  Description : Serial pins plus register-side strobes of the SSP slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ssp_slave_frame_deser_if #(
    parameter int NUM_CH = 1,
    parameter int RA_W   = 3,
    parameter int DATA_W = 12
);
    logic              SSEL_n;
    logic              SCK;
    logic              MOSI;
    logic              MISO;
    logic              MISO_oe;
    logic [NUM_CH-1:0] SSP_CH;
    logic [RA_W-1:0]   SSP_RA;
    logic              SSP_WnR;
    logic              SSP_En;
    logic              SSP_EOC;
    logic [DATA_W-1:0] SSP_DI;
    logic [DATA_W-1:0] SSP_DO;
    logic              Frm_Err;

    modport slave (
        input  SSEL_n, SCK, MOSI, SSP_DO,
        output MISO, MISO_oe, SSP_CH, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI, Frm_Err
    );

    modport master (
        output SSEL_n, SCK, MOSI, SSP_DO,
        input  MISO, MISO_oe, SSP_CH, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI, Frm_Err
    );
endinterface
`default_nettype wire

// File: rtl/ssp_slave_frame_deser_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_sync_edge
//  Description : SYNC_N-flop synchroniser with rise/fall detection on the
//                synchronised copy.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssp_sync_edge #(
    parameter int   SYNC_N  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_N-1:0] r_sync;
    logic              r_prev;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_N{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], i_d};
            r_prev <= r_sync[SYNC_N-1];
        end
    end

    assign o_q    = r_sync[SYNC_N-1];
    assign o_rise =  r_sync[SYNC_N-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_N-1] &  r_prev;
endmodule
`default_nettype wire

// File: rtl/ssp_slave_frame_deser.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_slave_frame_deser
//  Description : Oversampled SSP slave: deserialises [ch|ra|WnR|data] frames,
//                strobes the register file and serialises read data on MISO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssp_slave_frame_deser #(
    parameter int NUM_CH = 1,
    parameter int RA_W   = 3,
    parameter int DATA_W = 12,
    parameter int SYNC_N = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    ssp_slave_frame_deser_if.slave  bus
);
    import ssp_pkg::*;

    localparam int c_CH_W    = ch_w(NUM_CH);
    localparam int c_HDR_W   = c_CH_W + RA_W + 1;
    localparam int c_FRAME_W = frame_w(c_CH_W, RA_W, DATA_W);
    localparam int c_CNT_W   = $clog2(c_FRAME_W + 1);
    localparam int c_IDX_W   = (c_CH_W > 0) ? c_CH_W : 1;
    localparam logic [NUM_CH-1:0] c_CH_ONE = NUM_CH'(1);

    logic w_sck_q,  w_sck_rise,  w_sck_fall;
    logic w_ssel_q, w_ssel_rise, w_ssel_fall;
    logic w_mosi_q, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    ssp_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b0)) u_sync_sck (
        .clk(Clk), .rst(Rst), .i_d(bus.SCK),
        .o_q(w_sck_q), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    ssp_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b1)) u_sync_ssel (
        .clk(Clk), .rst(Rst), .i_d(bus.SSEL_n),
        .o_q(w_ssel_q), .o_rise(w_ssel_rise), .o_fall(w_ssel_fall)
    );
    ssp_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(Clk), .rst(Rst), .i_d(bus.MOSI),
        .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_sck_q, w_ssel_rise, w_mosi_rise, w_mosi_fall};

    ssp_state_e          r_state;
    logic                r_err_arm;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_HDR_W-2:0]  r_hdr_sr;
    logic [DATA_W-2:0]   r_rx_sr;
    logic [DATA_W-1:0]   r_tx;
    logic                r_load;
    logic                r_ch_ok;
    logic                r_en, r_eoc, r_err;
    logic                r_miso, r_miso_oe;
    logic [NUM_CH-1:0]   r_ch;
    logic [RA_W-1:0]     r_ra;
    logic                r_wnr;
    logic [DATA_W-1:0]   r_di;
    logic [SYNC_N:0]     r_boot;

    // Shift registers viewed with the current MOSI bit appended.
    logic [c_HDR_W-1:0] w_hdr;
    logic [DATA_W-1:0]  w_rx;
    logic [c_IDX_W-1:0] w_ch_idx;
    logic               w_ch_ok;

    assign w_hdr = {r_hdr_sr, w_mosi_q};
    assign w_rx  = {r_rx_sr, w_mosi_q};

    generate
        if (c_CH_W > 0) begin : g_ch_field
            assign w_ch_idx = w_hdr[c_HDR_W-1 -: c_IDX_W];
        end else begin : g_no_ch_field
            assign w_ch_idx = '0;
        end
    endgenerate

    assign w_ch_ok = (int'(w_ch_idx) < NUM_CH);

    // Marks when the synchronisers hold real samples rather than reset values,
    // so a select line held low across reset is never mistaken for a new frame.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_boot <= '0;
        else     r_boot <= {r_boot[SYNC_N-1:0], 1'b1};
    end

    // Frame sequencer with registered strobes and serial output.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= WAIT;
            r_err_arm <= 1'b0;
            r_cnt     <= '0;
            r_hdr_sr  <= '0;
            r_rx_sr   <= '0;
            r_tx      <= '0;
            r_load    <= 1'b0;
            r_ch_ok   <= 1'b0;
            r_en      <= 1'b0;
            r_eoc     <= 1'b0;
            r_err     <= 1'b0;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
            r_ch      <= '0;
            r_ra      <= '0;
            r_wnr     <= 1'b0;
            r_di      <= '0;
        end else begin
            r_en   <= 1'b0;
            r_eoc  <= 1'b0;
            r_err  <= 1'b0;
            r_load <= 1'b0;
            if (r_load) r_tx <= bus.SSP_DO;
            case (r_state)
                IDLE: begin
                    if (w_ssel_fall) begin
                        r_state <= HDR;
                        r_cnt   <= '0;
                        // A coincident SCK rise is the first header bit.
                        if (w_sck_rise) begin
                            r_hdr_sr <= w_hdr[c_HDR_W-2:0];
                            r_cnt    <= c_CNT_W'(1);
                        end
                    end
                end
                HDR: begin
                    if (w_ssel_q) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_sck_rise) begin
                        r_hdr_sr <= w_hdr[c_HDR_W-2:0];
                        if (r_cnt == c_CNT_W'(c_HDR_W-1)) begin
                            r_ra      <= w_hdr[RA_W:1];
                            r_wnr     <= w_hdr[0];
                            r_ch_ok   <= w_ch_ok;
                            r_ch      <= w_ch_ok ? (c_CH_ONE << w_ch_idx) : '0;
                            r_en      <= w_ch_ok;
                            r_load    <= w_ch_ok & ~w_hdr[0];
                            r_miso_oe <= w_ch_ok & ~w_hdr[0];
                            r_cnt     <= '0;
                            r_state   <= DATA;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (w_ssel_q) begin
                        r_err     <= 1'b1;
                        r_miso_oe <= 1'b0;
                        r_miso    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        if (w_sck_fall && r_miso_oe) begin
                            r_miso <= r_tx[DATA_W-1];
                            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                        end
                        if (w_sck_rise) begin
                            r_rx_sr <= w_rx[DATA_W-2:0];
                            if (r_cnt == c_CNT_W'(DATA_W-1)) begin
                                if (r_ch_ok) begin
                                    r_eoc <= 1'b1;
                                    if (r_wnr) r_di <= w_rx;
                                end else begin
                                    r_err <= 1'b1;
                                end
                                r_miso_oe <= 1'b0;
                                r_miso    <= 1'b0;
                                r_err_arm <= 1'b1;
                                r_state   <= WAIT;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_W'(1);
                            end
                        end
                    end
                end
                WAIT: begin
                    if (w_ssel_q && r_boot[SYNC_N]) begin
                        r_err_arm <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_sck_rise && r_err_arm) begin
                        r_err <= 1'b1;
                    end
                end
                default: r_state <= WAIT;
            endcase
        end
    end

    assign bus.MISO    = r_miso;
    assign bus.MISO_oe = r_miso_oe;
    assign bus.SSP_CH  = r_ch;
    assign bus.SSP_RA  = r_ra;
    assign bus.SSP_WnR = r_wnr;
    assign bus.SSP_En  = r_en;
    assign bus.SSP_EOC = r_eoc;
    assign bus.SSP_DI  = r_di;
    assign bus.Frm_Err = r_err;
endmodule
`default_nettype wire

// File: tb/tb_ssp_slave_frame_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssp_slave_frame_deser
//  Description : Scoreboard bench for two SSP slaves (1 and 3 channels) that
//                share SCK/MOSI but have separate selects.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ssp_slave_frame_deser;

    typedef struct packed {
        logic [1:0]  dut;
        logic [1:0]  kind;   // 1 = SSP_En, 2 = SSP_EOC, 3 = Frm_Err
        logic [2:0]  ch;
        logic [2:0]  ra;
        logic        wnr;
        logic [11:0] di;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        ssel1_n = 1'b1;
    logic        ssel3_n = 1'b1;
    logic [11:0] do1 = 12'h000;
    logic [11:0] do3 = 12'h000;

    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;

    ssp_slave_frame_deser_if #(.NUM_CH(1), .RA_W(3), .DATA_W(12)) bus1();
    ssp_slave_frame_deser_if #(.NUM_CH(3), .RA_W(3), .DATA_W(12)) bus3();

    assign bus1.SSEL_n = ssel1_n;
    assign bus1.SCK    = sck;
    assign bus1.MOSI   = mosi;
    assign bus1.SSP_DO = do1;
    assign bus3.SSEL_n = ssel3_n;
    assign bus3.SCK    = sck;
    assign bus3.MOSI   = mosi;
    assign bus3.SSP_DO = do3;

    ssp_slave_frame_deser #(.NUM_CH(1), .RA_W(3), .DATA_W(12), .SYNC_N(2)) dut1 (
        .Clk(clk), .Rst(rst), .bus(bus1)
    );
    ssp_slave_frame_deser #(.NUM_CH(3), .RA_W(3), .DATA_W(12), .SYNC_N(2)) dut3 (
        .Clk(clk), .Rst(rst), .bus(bus3)
    );

    function automatic ev_t ev_en(input logic [1:0] d, input logic [2:0] ra,
                                  input logic wnr, input logic [2:0] ch);
        ev_t e;
        e = '0; e.dut = d; e.kind = 2'd1; e.ra = ra; e.wnr = wnr; e.ch = ch;
        return e;
    endfunction

    function automatic ev_t ev_eoc(input logic [1:0] d, input logic [11:0] di);
        ev_t e;
        e = '0; e.dut = d; e.kind = 2'd2; e.di = di;
        return e;
    endfunction

    function automatic ev_t ev_err(input logic [1:0] d);
        ev_t e;
        e = '0; e.dut = d; e.kind = 2'd3;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic observe(input ev_t act);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %h expected none", act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                bad++;
                $display("FAIL event: got %h expected %h", act, e);
            end
        end
    endtask

    // Monitor: every strobe the DUTs present is matched against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (bus1.SSP_En)  observe(ev_en(2'd1, bus1.SSP_RA, bus1.SSP_WnR, {2'b00, bus1.SSP_CH}));
            if (bus1.SSP_EOC) observe(ev_eoc(2'd1, bus1.SSP_DI));
            if (bus1.Frm_Err) observe(ev_err(2'd1));
            if (bus3.SSP_En)  observe(ev_en(2'd3, bus3.SSP_RA, bus3.SSP_WnR, bus3.SSP_CH));
            if (bus3.SSP_EOC) observe(ev_eoc(2'd3, bus3.SSP_DI));
            if (bus3.Frm_Err) observe(ev_err(2'd3));
        end
    end

    // Clocks n bits out MSB first; optionally checks MISO/MISO_oe of dut1
    // just before each SCK rise (the master's sampling point).
    task automatic clock_bits(input int n, input logic [31:0] bits, input int hdr_n,
                              input logic chk, input logic [11:0] miso_exp);
        for (int i = 0; i < n; i++) begin
            mosi = bits[n-1-i];
            #40;
            if (chk) begin
                if (i < hdr_n) begin
                    check("miso_oe_hdr", 32'(bus1.MISO_oe), 32'd0);
                end else begin
                    check("miso_oe_data", 32'(bus1.MISO_oe), 32'd1);
                    check("miso_bit", 32'(bus1.MISO), 32'(miso_exp[11-(i-hdr_n)]));
                end
            end
            sck = 1'b1;
            #80;
            sck = 1'b0;
            #40;
        end
    endtask

    task automatic frame(input int d, input int n, input logic [31:0] bits,
                         input logic chk, input logic [11:0] miso_exp);
        if (d == 1) ssel1_n = 1'b0;
        else        ssel3_n = 1'b0;
        #40;
        clock_bits(n, bits, 4, chk, miso_exp);
        ssel1_n = 1'b1;
        ssel3_n = 1'b1;
        #300;
    endtask

    initial begin
        #20;
        check("rst_en",      32'(bus1.SSP_En),  32'd0);
        check("rst_eoc",     32'(bus1.SSP_EOC), 32'd0);
        check("rst_err",     32'(bus1.Frm_Err), 32'd0);
        check("rst_miso",    32'(bus1.MISO),    32'd0);
        check("rst_miso_oe", 32'(bus1.MISO_oe), 32'd0);
        check("rst_ch",      32'(bus1.SSP_CH),  32'd0);
        check("rst_ch3",     32'(bus3.SSP_CH),  32'd0);
        check("rst_di",      32'(bus1.SSP_DI),  32'd0);
        #13 rst = 1'b0;
        #200;

        // Write RA=5, data A5C.
        exp_q.push_back(ev_en(2'd1, 3'd5, 1'b1, 3'b001));
        exp_q.push_back(ev_eoc(2'd1, 12'hA5C));
        frame(1, 16, {16'h0, 4'b1011, 12'hA5C}, 1'b0, 12'h000);

        // Read RA=2 returning 3F1; SSP_DI keeps the previous write.
        do1 = 12'h3F1;
        exp_q.push_back(ev_en(2'd1, 3'd2, 1'b0, 3'b001));
        exp_q.push_back(ev_eoc(2'd1, 12'hA5C));
        frame(1, 16, {16'h0, 4'b0100, 12'h000}, 1'b1, 12'h3F1);
        check("miso_oe_after", 32'(bus1.MISO_oe), 32'd0);
        check("miso_after",    32'(bus1.MISO),    32'd0);

        // Select released after 8 bits, then a good write.
        exp_q.push_back(ev_en(2'd1, 3'd5, 1'b1, 3'b001));
        exp_q.push_back(ev_err(2'd1));
        frame(1, 8, {24'h0, 8'b1011_0110}, 1'b0, 12'h000);
        exp_q.push_back(ev_en(2'd1, 3'd1, 1'b1, 3'b001));
        exp_q.push_back(ev_eoc(2'd1, 12'h123));
        frame(1, 16, {16'h0, 4'b0011, 12'h123}, 1'b0, 12'h000);
        check("di_hold", 32'(bus1.SSP_DI), 32'h123);

        // 17 rises: EOC on the 16th, error on the extra bit.
        exp_q.push_back(ev_en(2'd1, 3'd3, 1'b1, 3'b001));
        exp_q.push_back(ev_eoc(2'd1, 12'hC3A));
        exp_q.push_back(ev_err(2'd1));
        frame(1, 17, {15'h0, 4'b0111, 12'hC3A, 1'b1}, 1'b0, 12'h000);

        // Three channels: index 3 is invalid, index 2 selects 3'b100.
        exp_q.push_back(ev_err(2'd3));
        frame(3, 18, {14'h0, 2'b11, 3'b010, 1'b1, 12'hABC}, 1'b0, 12'h000);
        check("ch3_invalid_ch", 32'(bus3.SSP_CH), 32'd0);
        exp_q.push_back(ev_en(2'd3, 3'd4, 1'b1, 3'b100));
        exp_q.push_back(ev_eoc(2'd3, 12'h5A5));
        frame(3, 18, {14'h0, 2'b10, 3'b100, 1'b1, 12'h5A5}, 1'b0, 12'h000);

        // Reset after 6 bits with the select held low; the tail is ignored.
        exp_q.push_back(ev_en(2'd1, 3'd6, 1'b1, 3'b001));
        ssel1_n = 1'b0;
        #40;
        clock_bits(6, {26'h0, 6'b1101_10}, 4, 1'b0, 12'h000);
        rst = 1'b1;
        #30;
        rst = 1'b0;
        #20;
        check("mid_rst_ra",  32'(bus1.SSP_RA),  32'd0);
        check("mid_rst_wnr", 32'(bus1.SSP_WnR), 32'd0);
        check("mid_rst_ch",  32'(bus1.SSP_CH),  32'd0);
        check("mid_rst_di",  32'(bus1.SSP_DI),  32'd0);
        clock_bits(10, {22'h0, 10'b11_1111_1111}, 4, 1'b0, 12'h000);
        ssel1_n = 1'b1;
        #300;
        exp_q.push_back(ev_en(2'd1, 3'd7, 1'b1, 3'b001));
        exp_q.push_back(ev_eoc(2'd1, 12'h0F0));
        frame(1, 16, {16'h0, 4'b1111, 12'h0F0}, 1'b0, 12'h000);

        #200;
        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
